// File: rtl/dec_scan_seq_if.sv
// Control/status bundle between the decoder scan sequencer and whatever drives it.
// oneshot/done are present only when SCAN_ONESHOT_EN is defined.
interface dec_scan_seq_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               dir;
  logic [SEL_W-1:0]   start_sel;
  logic [DWELL_W-1:0] dwell;
  logic [SEL_W-1:0]   dec_i;
  logic               dec_en;
  logic               busy;
  logic               wrap;
`ifdef SCAN_ONESHOT_EN
  logic               oneshot;
  logic               done;

  modport master (
    output start, stop, dir, start_sel, dwell, oneshot,
    input  dec_i, dec_en, busy, wrap, done
  );
  modport slave (
    input  start, stop, dir, start_sel, dwell, oneshot,
    output dec_i, dec_en, busy, wrap, done
  );
`else
  modport master (
    output start, stop, dir, start_sel, dwell,
    input  dec_i, dec_en, busy, wrap
  );
  modport slave (
    input  start, stop, dir, start_sel, dwell,
    output dec_i, dec_en, busy, wrap
  );
`endif
endinterface

// File: rtl/dec_scan_seq.sv
// Scan sequencer for the 3-to-8 decoder: steps dec_i through all codes with a dwell and a 1-cycle blanking gap.
// Latency: outputs registered, dec_en rises 1 cycle after start; no backpressure, stop halts on the next edge.
// SCAN_ONESHOT_EN adds oneshot/done: a single 8-code sweep ending in IDLE.
module dec_scan_seq #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input logic           clk,
  input logic           rst,
  dec_scan_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dw_q, dw_d;

  logic [DWELL_W-1:0] cnt_inc;
  logic               dwell_last;
  logic [SEL_W-1:0]   sel_adv;
  logic               adv_wraps;
  logic               finish;

`ifdef SCAN_ONESHOT_EN
  logic               os_q, os_d;
  logic               done_q, done_d;
  logic [SEL_W-1:0]   codes_q, codes_d;

  // codes_q counts codes already presented; the 8th code ends a oneshot sweep
  assign finish = os_q && (codes_q == '1);
`else
  assign finish = 1'b0;
`endif

  assign cnt_inc    = cnt_q + DWELL_W'(1);
  assign dwell_last = (cnt_inc == dw_q);
  assign sel_adv    = bus.dir ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
  assign adv_wraps  = bus.dir ? (sel_q == '0) : (sel_q == '1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    dw_d    = dw_q;
`ifdef SCAN_ONESHOT_EN
    os_d    = os_q;
    codes_d = codes_q;
    done_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          sel_d   = bus.start_sel;
          cnt_d   = '0;
          dw_d    = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
          en_d    = 1'b1;
          busy_d  = 1'b1;
`ifdef SCAN_ONESHOT_EN
          os_d    = bus.oneshot;
          codes_d = '0;
`endif
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (dwell_last && finish) begin
          // end of a oneshot sweep: blank and hold the last code, no advance
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
`ifdef SCAN_ONESHOT_EN
          done_d  = 1'b1;
`endif
        end else if (dwell_last) begin
          state_d = GAP;
          en_d    = 1'b0;
          sel_d   = sel_adv;
          wrap_d  = adv_wraps;
          cnt_d   = '0;
`ifdef SCAN_ONESHOT_EN
          codes_d = codes_q + SEL_W'(1);
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GAP: begin
        if (bus.stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          state_d = RUN;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      dw_q    <= DWELL_W'(1);
`ifdef SCAN_ONESHOT_EN
      os_q    <= 1'b0;
      done_q  <= 1'b0;
      codes_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      dw_q    <= dw_d;
`ifdef SCAN_ONESHOT_EN
      os_q    <= os_d;
      done_q  <= done_d;
      codes_q <= codes_d;
`endif
    end
  end

  assign bus.dec_i  = sel_q;
  assign bus.dec_en = en_q;
  assign bus.busy   = busy_q;
  assign bus.wrap   = wrap_q;
`ifdef SCAN_ONESHOT_EN
  assign bus.done   = done_q;
`endif

endmodule

// File: doc/dec_scan_seq.md
Name: dec_scan_seq

Overview:
- Upstream sequencer for the 3-to-8 decoder stage.
- Generates the 3-bit select (dec_i) and the enable (dec_en) that drive the decoder's i and en inputs.
- Steps the select through all eight codes, up or down, holding each code enabled for a programmable dwell.
- Inserts a one-cycle blanking gap between codes so two decoder outputs are never active in consecutive enabled cycles without a gap (break-before-make).

Parameters:
- SEL_W, 3, select width; fixed at 3 to match the decoder.
- DWELL_W, 8, width of the dwell input and the internal dwell counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin scanning; honoured only in IDLE.
- stop  input  1  one-cycle request to halt; honoured in RUN or GAP.
- dir  input  1  0 = count up, 1 = count down; sampled at each advance.
- start_sel  input  SEL_W  first code, sampled when start is honoured.
- dwell  input  DWELL_W  enabled cycles per code, sampled when start is honoured; 0 is treated as 1.
- dec_i  output  SEL_W  select to the decoder; registered.
- dec_en  output  1  enable to the decoder; registered.
- busy  output  1  high in RUN and GAP.
- wrap  output  1  one-cycle pulse when dec_i wraps (7->0 up, 0->7 down).

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, dec_i=0, dec_en=0, busy=0, wrap=0, dwell counter=0, latched dwell=1.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - dec_en=0; dec_i holds its last value.
  - On start=1 (and stop=0): latch D = max(dwell,1), load dec_i=start_sel, clear the counter, and enter RUN.
  - dec_en and busy go 1 on the following edge (latency 1 cycle from start).
- RUN:
  - dec_en=1. The counter increments each cycle.
  - On the Dth enabled cycle, enter GAP.
  - Exactly D consecutive dec_en=1 cycles per code.
- GAP:
  - Exactly one cycle long, with dec_en=0.
  - dec_i advances on GAP entry: +1 mod 8 if dir=0, -1 mod 8 if dir=1, using dir sampled on that edge.
  - wrap=1 in that same cycle if the advance wrapped; 0 otherwise.
  - Then return to RUN with the counter cleared.
- Code period is D+1 cycles; a full sweep takes 8*(D+1) cycles.
- stop:
  - In RUN or GAP, the next edge enters IDLE with dec_en=0, busy=0, wrap=0.
  - dec_i holds and does not advance, even if stop coincides with the last dwell cycle.
- Simultaneous events:
  - start and stop together in IDLE: stop wins, stay IDLE.
  - start while busy is ignored; dwell and start_sel changes while busy are ignored.
  - A dir change takes effect at the next advance only.
- Reset mid-scan: immediate return to reset values regardless of state; no wrap pulse generated.
- wrap is never asserted in IDLE or RUN.

Optional Feature:
- Macro SCAN_ONESHOT_EN.
- Defined:
  - Adds input oneshot (1 bit, sampled with start) and output done (1 bit).
  - With oneshot=1, the sequencer presents exactly 8 codes.
  - After the 8th code's dwell, it enters IDLE instead of GAP: dec_en=0, dec_i holds the 8th code, no advance, no wrap pulse.
  - done pulses for one cycle on that IDLE entry.
  - oneshot=0 behaves as continuous. A stop before completion produces no done. done resets to 0.
- Not defined: no oneshot/done ports; scanning is always continuous until stop or reset.

Test Plan:
- Reset, then start with start_sel=3'b110, dwell=2, dir=0 -> dec_en 1 cycle later. dec_i=6 for 2 cycles, GAP (en=0, dec_i=7), 7 for 2 cycles, GAP (dec_i=0, wrap=1 for one cycle), then 0.
- dwell=0, start_sel=3'b100, dir=1 -> D=1. Sequence en pattern 1,0,1,0 with dec_i 4,3,3,2,...; wrap when 0->7.
- stop asserted during the last dwell cycle of code 5 -> next cycle IDLE, dec_en=0, busy=0, dec_i stays 5. A new start while busy is ignored.
- start and stop asserted together in IDLE -> stays IDLE, dec_en=0. Async rst mid-RUN (between edges) -> dec_i=0, dec_en=0, busy=0 immediately.
- dir toggled 0->1 mid-dwell on code 2 -> the next advance goes to 1, not 3.
- SCAN_ONESHOT_EN, oneshot=1, start_sel=0, dwell=1, dir=0:
  - dec_i presents 0..7 with en pattern 1,0 repeated.
  - After code 7's enabled cycle, IDLE with dec_i=7, done pulses once, and no wrap occurs.
